rca_mp_sequencer: RTL

Multi-precision add controller that time-multiplexes one 32-bit ripple-carry adder slice over NWORDS 32-bit words, least-significant word first. The carry is held in a register between words. Operands are captured on a start pulse and the result is returned with a busy/done handshake. It serves as the wide-operand front end for the team's 32-bit RCA datapath, avoiding a 32*NWORDS-bit ripple chain.

---
 rtl/rca_mp_sequencer_if.sv | 33 +++
 rtl/rca_mp_sequencer.sv | 100 ++++++++++
 2 files changed

// File: rtl/rca_mp_sequencer_if.sv
// Request/result bundle for the multi-precision add sequencer.
// Optional build macro: SUB_EN adds the 'sub' request bit.
interface rca_mp_sequencer_if #(
    parameter int NWORDS = 4
) ();
    logic                   start;
    logic [32*NWORDS-1:0]   a;
    logic [32*NWORDS-1:0]   b;
    logic                   cin;
`ifdef SUB_EN
    logic                   sub;
`endif
    logic                   busy;
    logic                   done;
    logic [32*NWORDS-1:0]   sum;
    logic                   cout;

    modport master (
        output start, a, b, cin,
`ifdef SUB_EN
        output sub,
`endif
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
`ifdef SUB_EN
        input  sub,
`endif
        output busy, done, sum, cout
    );
endinterface

// File: rtl/rca_mp_sequencer.sv
// Multi-precision adder: one 32-bit ripple slice reused over NWORDS words, LSW first.
// Optional build macro: SUB_EN enables a-b via inverted B and forced carry-in.
module rca_mp_sequencer #(
    parameter int NWORDS = 4,
    parameter int IDXW   = 2
) (
    input  logic              clk,
    input  logic              rst,
    rca_mp_sequencer_if.slave bus
);
    localparam logic [IDXW-1:0] LAST = IDXW'(NWORDS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state, state_nxt;
    logic [NWORDS-1:0][31:0] a_reg, b_reg, sum_r;
    logic [IDXW-1:0]         idx;
    logic                    carry;
    logic                    cout_r;
    logic                    done_r;
    logic                    capture, step, last;
    logic [31:0]             b_word;
    logic [32:0]             slice;
`ifdef SUB_EN
    logic                    sub_reg;
`endif

    function automatic logic [32:0] slice_add(input logic [31:0] x,
                                              input logic [31:0] y,
                                              input logic        ci);
        return {1'b0, x} + {1'b0, y} + {32'd0, ci};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (idx == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // start is only honoured from IDLE, which also covers the done cycle
    always_comb begin
        capture = (state == IDLE) && bus.start;
        step    = (state == RUN);
        last    = step && (idx == LAST);
    end

    // Slice inputs come only from captured registers, never from the ports
`ifdef SUB_EN
    assign b_word = sub_reg ? ~b_reg[idx] : b_reg[idx];
`else
    assign b_word = b_reg[idx];
`endif
    assign slice = slice_add(a_reg[idx], b_word, carry);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sum_r   <= '0;
            idx     <= '0;
            carry   <= 1'b0;
            cout_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef SUB_EN
            sub_reg <= 1'b0;
`endif
        end else begin
            done_r <= last;
            if (capture) begin
                a_reg <= bus.a;
                b_reg <= bus.b;
                idx   <= '0;
`ifdef SUB_EN
                sub_reg <= bus.sub;
                carry   <= bus.sub ? 1'b1 : bus.cin;
`else
                carry   <= bus.cin;
`endif
            end else if (step) begin
                sum_r[idx] <= slice[31:0];
                carry      <= slice[32];
                idx        <= idx + IDXW'(1);
                if (last) cout_r <= slice[32];
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
endmodule
